// File: rtl/ins_mem_loadable.sv
// Loadable instruction memory: cleared to FILL_WORD after reset,
// streamed program load port, registered 1-cycle fetch.
module ins_mem_loadable #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] FILL_WORD = 16'h0800
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] load_wdata,
  input  logic              load_wvalid,
  output logic              load_wready,
  output logic              load_done
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEP  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOAD
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W:0]   clr_ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W:0]   base_mod;
  logic              wen_clr;
  logic              wen_ld;
  logic              last_word;
  logic              fetch_ok;
  logic              in_range;
  logic              wen;
  logic [IW-1:0]     wa;
  logic [DATA_W-1:0] wd;

  logic [DATA_W-1:0] mem [DEPTH];

  // Zero or oversize lengths mean a full-memory load
  assign len_eff   = (load_len == '0 || load_len > DEP) ? DEP : load_len;
  assign base_mod  = {1'b0, load_base} % DEP;
  assign last_word = (cnt == len - 1'b1);
  assign fetch_ok  = fetch_en & ~busy;
  assign in_range  = ({1'b0, addr} < DEP);

  always_ff @(posedge mem_clk) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    busy        = 1'b1;
    load_wready = 1'b0;
    wen_clr     = 1'b0;
    wen_ld      = 1'b0;
    unique case (state)
      CLEAR: begin
        wen_clr = 1'b1;
        if (clr_ptr == LAST) state_nx = IDLE;
      end
      IDLE: begin
        busy = 1'b0;
        if (load_start) state_nx = LOAD;
      end
      LOAD: begin
        load_wready = 1'b1;
        wen_ld      = load_wvalid;
        if (load_wvalid && last_word) state_nx = IDLE;
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      clr_ptr   <= '0;
      cnt       <= '0;
      len       <= '0;
      wptr      <= '0;
      rdata     <= FILL_WORD;
      rvalid    <= 1'b0;
      load_done <= 1'b0;
    end else begin
      load_done <= wen_ld & last_word;
      if (wen_clr) clr_ptr <= clr_ptr + 1'b1;
      if (state == IDLE && load_start) begin
        len  <= len_eff;
        cnt  <= '0;
        wptr <= base_mod;
      end
      if (wen_ld) begin
        cnt  <= cnt + 1'b1;
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      end
      rvalid <= fetch_ok;
      if (fetch_ok)
        rdata <= in_range ? mem[addr[IW-1:0]] : FILL_WORD;
    end
  end

  always_comb begin
    wen = 1'b0;
    wa  = wptr[IW-1:0];
    wd  = load_wdata;
    unique case (1'b1)
      wen_clr: begin
        wen = 1'b1;
        wa  = clr_ptr[IW-1:0];
        wd  = FILL_WORD;
      end
      wen_ld: wen = 1'b1;
      default: wen = 1'b0;
    endcase
  end

  // Writes are gated by rst_n so a reset abandons an in-flight word
  always_ff @(posedge mem_clk) begin
    if (rst_n && wen) mem[wa] <= wd;
  end

endmodule
